// File: rtl/rom_serial_link_if.sv
// rom_serial_link_if: burst request handshake plus serial stream and receiver outputs.
interface rom_serial_link_if #(
    parameter int WIDTH = 8,
    parameter int AW = 2
);
    logic start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] burst_len;
    logic busy;
    logic so;
    logic so_valid;
    logic [WIDTH-1:0] rx_word;
    logic rx_valid;
    logic done;
    modport master (
        output start, start_addr, burst_len,
        input busy, so, so_valid, rx_word, rx_valid, done
    );
    modport slave (
        input start, start_addr, burst_len,
        output busy, so, so_valid, rx_word, rx_valid, done
    );
endinterface

// File: rtl/rom_serial_link.sv
// rom_serial_link: bursts constant-ROM words through a PISO stage into a loopback SIPO receiver.
module rom_serial_link #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH),
    parameter int MSB_FIRST = 1
) (
    input logic clk,
    input logic rst,
    rom_serial_link_if.slave s
);
    localparam int BW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, rx_sh_q, rx_sh_d, rx_word_q, rx_word_d;
    logic [WIDTH-1:0] rom_word, rx_next;
    logic [BW-1:0] bit_q, bit_d;
    logic [AW-1:0] wcnt_q, wcnt_d, len_q, len_d, cur_q, cur_d;
    logic rx_valid_q, rx_valid_d;
    logic so_bit;
    assign rom_word = WIDTH'(32'(cur_q) * 32'd167 + 32'd15);
    assign so_bit = MSB_FIRST != 0 ? sr_q[WIDTH-1] : sr_q[0];
    assign rx_next = MSB_FIRST != 0 ? {rx_sh_q[WIDTH-2:0], so_bit} : {so_bit, rx_sh_q[WIDTH-1:1]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q <= '0;
            rx_sh_q <= '0;
            rx_word_q <= '0;
            bit_q <= '0;
            wcnt_q <= '0;
            len_q <= '0;
            cur_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q <= sr_d;
            rx_sh_q <= rx_sh_d;
            rx_word_q <= rx_word_d;
            bit_q <= bit_d;
            wcnt_q <= wcnt_d;
            len_q <= len_d;
            cur_q <= cur_d;
            rx_valid_q <= rx_valid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        sr_d = sr_q;
        rx_sh_d = rx_sh_q;
        rx_word_d = rx_word_q;
        bit_d = bit_q;
        wcnt_d = wcnt_q;
        len_d = len_q;
        cur_d = cur_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: if (s.start) begin
                state_d = LOAD;
                cur_d = 32'(s.start_addr) >= DEPTH ? '0 : s.start_addr;
                len_d = s.burst_len;
                wcnt_d = '0;
            end
            LOAD: begin
                sr_d = rom_word;
                bit_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d = MSB_FIRST != 0 ? sr_q << 1 : sr_q >> 1;
                rx_sh_d = rx_next;
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(WIDTH - 1)) begin
                    rx_word_d = rx_next;
                    rx_valid_d = 1'b1;
                    state_d = wcnt_q == len_q ? DONE : LOAD;
                    wcnt_d = wcnt_q == len_q ? wcnt_q : wcnt_q + 1'b1;
                    cur_d = wcnt_q == len_q ? cur_q : (cur_q == AW'(DEPTH - 1) ? '0 : cur_q + 1'b1);
                end
            end
            DONE: state_d = IDLE;
        endcase
    end
    assign s.busy = state_q == LOAD || state_q == SHIFT;
    assign s.so = state_q == SHIFT && so_bit;
    assign s.so_valid = state_q == SHIFT;
    assign s.rx_word = rx_word_q;
    assign s.rx_valid = rx_valid_q;
    assign s.done = state_q == DONE;
endmodule

// File: tb/tb_rom_serial_link.sv
// tb_rom_serial_link: MSB-first, LSB-first and DEPTH=5 instances driven in lockstep against a ROM/burst model.
module tb_rom_serial_link;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [2:0] addr;
    logic [1:0] len;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    rom_serial_link_if #(.WIDTH(8), .AW(2)) i0 ();
    rom_serial_link_if #(.WIDTH(8), .AW(2)) i1 ();
    rom_serial_link_if #(.WIDTH(8), .AW(3)) i2 ();
    assign i0.start = start;
    assign i1.start = start;
    assign i2.start = start;
    assign i0.start_addr = addr[1:0];
    assign i1.start_addr = addr[1:0];
    assign i2.start_addr = addr;
    assign i0.burst_len = len;
    assign i1.burst_len = len;
    assign i2.burst_len = {1'b0, len};
    rom_serial_link #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) d0 (.clk(clk), .rst(rst), .s(i0));
    rom_serial_link #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) d1 (.clk(clk), .rst(rst), .s(i1));
    rom_serial_link #(.WIDTH(8), .DEPTH(5), .MSB_FIRST(1)) d2 (.clk(clk), .rst(rst), .s(i2));
    typedef struct {
        logic [2:0] a;
        logic [1:0] l;
        bit hold;
        logic [7:0] f4;
        logic [7:0] f5;
    } vec_t;
    vec_t vecs[5];
    function automatic logic [7:0] exp_word(int d, int a, int i);
        int depth = d == 2 ? 5 : 4;
        int ae = d == 2 ? a : a % 4;
        if (ae >= depth) ae = 0;
        return 8'((((ae + i) % depth) * 167 + 15) % 256);
    endfunction
    task automatic chk(string n, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", n, d, act, exp, $time);
        end
    endtask
    task automatic look(int d, output logic b, output logic so, output logic sv, output logic rv, output logic dn, output logic [7:0] w);
        case (d)
            0: begin b = i0.busy; so = i0.so; sv = i0.so_valid; rv = i0.rx_valid; dn = i0.done; w = i0.rx_word; end
            1: begin b = i1.busy; so = i1.so; sv = i1.so_valid; rv = i1.rx_valid; dn = i1.done; w = i1.rx_word; end
            default: begin b = i2.busy; so = i2.so; sv = i2.so_valid; rv = i2.rx_valid; dn = i2.done; w = i2.rx_word; end
        endcase
    endtask
    task automatic ctl(string n, logic eb, logic esv, logic erv, logic edn);
        logic b, so, sv, rv, dn;
        logic [7:0] w;
        for (int d = 0; d < 3; d++) begin
            look(d, b, so, sv, rv, dn, w);
            chk({n, " busy"}, d, 32'(b), 32'(eb));
            chk({n, " so_valid"}, d, 32'(sv), 32'(esv));
            chk({n, " rx_valid"}, d, 32'(rv), 32'(erv));
            chk({n, " done"}, d, 32'(dn), 32'(edn));
            if (!esv) chk({n, " so idle"}, d, 32'(so), 32'(0));
        end
    endtask
    task automatic shift_bits(int a, int w, int nbits);
        logic b, so, sv, rv, dn;
        logic [7:0] wd, ew;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            ctl("shift", 1'b1, 1'b1, 1'b0, 1'b0);
            for (int d = 0; d < 3; d++) begin
                look(d, b, so, sv, rv, dn, wd);
                ew = exp_word(d, a, w);
                chk("so bit", d, 32'(so), 32'(d == 1 ? ew[k] : ew[7-k]));
            end
        end
    endtask
    task automatic burst(logic [2:0] a, logic [1:0] l, bit hold, bit usef, logic [7:0] f4, logic [7:0] f5);
        logic b, so, sv, rv, dn;
        logic [7:0] wd;
        @(negedge clk);
        start = 1'b1;
        addr = a;
        len = l;
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            addr = 3'($urandom);
            len = 2'($urandom);
        end
        ctl("load", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w <= int'(l); w++) begin
            shift_bits(a, w, 8);
            @(negedge clk);
            ctl("word end", w != int'(l), 1'b0, 1'b1, w == int'(l));
            for (int d = 0; d < 3; d++) begin
                look(d, b, so, sv, rv, dn, wd);
                chk("rx_word", d, 32'(wd), 32'(exp_word(d, a, w)));
                if (usef && w == 0) chk("rx_word first", d, 32'(wd), 32'(d == 2 ? f5 : f4));
            end
        end
        @(negedge clk);
        ctl("idle after done", 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
    endtask
    initial begin
        logic b, so, sv, rv, dn;
        logic [7:0] wd;
        vecs[0] = '{3'd0, 2'd0, 1'b0, 8'h0F, 8'h0F};
        vecs[1] = '{3'd3, 2'd1, 1'b0, 8'h04, 8'h04};
        vecs[2] = '{3'd1, 2'd0, 1'b0, 8'hB6, 8'hB6};
        vecs[3] = '{3'd0, 2'd3, 1'b1, 8'h0F, 8'h0F};
        vecs[4] = '{3'd5, 2'd0, 1'b0, 8'hB6, 8'h0F};
        rst = 1'b1;
        start = 1'b0;
        addr = '0;
        len = '0;
        repeat (2) @(negedge clk);
        ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            look(d, b, so, sv, rv, dn, wd);
            chk("reset rx_word", d, 32'(wd), 32'(0));
        end
        rst = 1'b0;
        for (int v = 0; v < 5; v++) burst(vecs[v].a, vecs[v].l, vecs[v].hold, 1'b1, vecs[v].f4, vecs[v].f5);
        @(negedge clk);
        start = 1'b1;
        addr = 3'd0;
        len = 2'd1;
        @(negedge clk);
        start = 1'b0;
        ctl("rst load", 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(0, 0, 4);
        #1 rst = 1'b1;
        #1;
        ctl("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            look(d, b, so, sv, rv, dn, wd);
            chk("async reset rx_word", d, 32'(wd), 32'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            ctl("after reset", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        burst(3'd2, 2'd1, 1'b0, 1'b1, 8'h5D, 8'h5D);
        for (int r = 0; r < 20; r++) burst(3'($urandom), 2'($urandom), 1'($urandom), 1'b0, 8'h00, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_serial_link.md
Name: rom_serial_link

Overview:
Parametrised ROM-to-serial transfer engine with an internal loopback receiver.
- On `start`, it reads a burst of consecutive words from an internal constant ROM.
- Each word is serialised one bit per clock through a PISO stage.
- A SIPO receiver reassembles each word and flags it with a one-cycle `rx_valid` pulse.
- It replaces the fixed 4x8 ROM / mux / PISO / shift-register chain, adding burst addressing, bit-order selection and a start/busy/done handshake.

Parameters:
- WIDTH, 8, word width in bits (>= 2)
- DEPTH, 4, number of ROM entries (>= 2; need not be a power of two)
- AW, $clog2(DEPTH), address width
- MSB_FIRST, 1, 1 = serialise MSB first, 0 = LSB first

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a burst; sampled only in IDLE
- start_addr  input  AW  first ROM address of the burst
- burst_len  input  AW  number of words minus one (0 = one word)
- busy  output  1  high in LOAD and SHIFT
- so  output  1  serial data; 0 outside SHIFT
- so_valid  output  1  high on every SHIFT cycle
- rx_word  output  WIDTH  last reassembled word; holds its value until the next word completes
- rx_valid  output  1  one-cycle pulse when rx_word updates
- done  output  1  one-cycle pulse at burst end

Behaviour:
- **Single clock; reset asynchronous, active-high.**
- **Reset values:** state = IDLE; shift register, bit counter, word counter, current address, rx_word all 0; busy, so, so_valid, rx_valid, done all 0.
- **ROM contents:** ROM[k] = (k*167 + 15) mod 2^WIDTH for k = 0..DEPTH-1. For WIDTH=8 this gives 0x0F, 0xB6, 0x5D, 0x04, ...
- **States:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:**
  - If start=1 at the clock edge: capture start_addr and burst_len, then go to LOAD.
  - start_addr >= DEPTH is captured as 0.
- **LOAD** (1 cycle): shift register <= ROM[cur_addr]; bit counter <= 0; go to SHIFT.
- **SHIFT** (exactly WIDTH cycles):
  - so = shift-register MSB if MSB_FIRST=1, else LSB.
  - so_valid = 1.
  - Each edge: the shift register shifts toward the output bit, and the receiver shifts in so in the same bit order, so rx_word reproduces the ROM word.
  - On the edge sampling the last bit:
    - rx_word is updated and rx_valid = 1 for the next cycle.
    - If the word counter equals burst_len, go to DONE.
    - Otherwise increment the word counter, set cur_addr = (cur_addr == DEPTH-1) ? 0 : cur_addr+1, and go to LOAD.
- **DONE** (1 cycle): done = 1, then go to IDLE. done coincides with the rx_valid of the final word.
- **Throughput and latency:**
  - Throughput: WIDTH+1 cycles per word.
  - Latency from start edge E0: first so bit in the cycle after E1; first rx_valid in the cycle after E(WIDTH+1).
- **start ignored:** start is ignored in LOAD, SHIFT and DONE; no queuing. A start arriving in DONE is lost, and the next accepted start is the earliest one sampled in IDLE.
- **Input changes during a burst:** start_addr and burst_len changes during a burst have no effect.
- **Address wrap:** wraps at DEPTH-1 to 0. A burst longer than DEPTH re-reads entries in order.
- **Reset mid-burst:** immediately clears all state and outputs, including rx_word. No done pulse.

Test Plan:
1. WIDTH=8, DEPTH=4, MSB_FIRST=1; start at E0 with start_addr=0, burst_len=0:
   - so sequence 0,0,0,0,1,1,1,1 with so_valid high for 8 cycles.
   - rx_word=0x0F and rx_valid=1 in the cycle after E9.
   - done=1 in that same cycle; busy=0 from then on.
2. start_addr=3, burst_len=1 (address wrap):
   - rx_word 0x04 then 0x0F.
   - rx_valid pulses exactly 9 cycles apart; single done with the second pulse.
3. MSB_FIRST=0, start_addr=1, burst_len=0:
   - so sequence 0,1,1,0,1,1,0,1.
   - rx_word=0xB6.
4. burst_len=3, start_addr=0, with start re-asserted on every cycle while busy:
   - exactly 4 words 0x0F, 0xB6, 0x5D, 0x04 and one done.
   - no second burst begins until after the done cycle.
5. Reset asserted at the 4th SHIFT cycle of a 2-word burst:
   - all outputs 0 within the same cycle (asynchronous); no rx_valid or done.
   - a fresh start afterwards completes normally.
6. start_addr=5 (>= DEPTH), burst_len=0:
   - reads ROM[0]; rx_word=0x0F.
